// File: rtl/sipo_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
package sipo_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } rx_state_t;

    localparam logic START_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/rx_word_buffer.sv
// One-entry valid/ready holding register for a received word and its flag.
module rx_word_buffer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_flag,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              flag,
    output logic              accepted
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              flag_q, flag_d;

    always_comb begin
        // A load is taken when the slot is empty or being drained on this same edge.
        accepted = load && (!valid_q || ready);
        valid_d  = valid_q;
        data_d   = data_q;
        flag_d   = flag_q;
        if (accepted) begin
            valid_d = 1'b1;
            data_d  = load_data;
            flag_d  = load_flag;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign flag  = flag_q;

endmodule

// File: rtl/sipo_frame_receiver.sv
// Serial-in parallel-out frame receiver: start bit, DATA_W data bits, optional even parity,
// delivered through a one-entry valid/ready buffer.
module sipo_frame_receiver
    import sipo_rx_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              overrun_q, overrun_d;

    logic [DATA_W-1:0] shift_in;
    logic              last_bit;
    logic              frame_done;
    logic [DATA_W-1:0] frame_data;
    logic              frame_perr;
    logic              accepted;

    assign shift_in = (MSB_FIRST != 0) ? {shift_q[DATA_W-2:0], serial_in}
                                       : {serial_in, shift_q[DATA_W-1:1]};
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                if (serial_in == START_LEVEL) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                shift_d = shift_in;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    state_d = (PARITY_EN != 0) ? PARITY : IDLE;
                end
            end
            PARITY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Without parity the frame completes on the last data edge, so the word includes that bit.
    always_comb begin
        busy       = (state_q != IDLE);
        frame_done = 1'b0;
        frame_data = shift_q;
        frame_perr = 1'b0;
        if (state_q == PARITY) begin
            frame_done = 1'b1;
            frame_perr = (^shift_q) ^ serial_in;
        end else if (state_q == SHIFT && last_bit && PARITY_EN == 0) begin
            frame_done = 1'b1;
            frame_data = shift_in;
        end
    end

    assign overrun_d = frame_done && !accepted;

    rx_word_buffer #(
        .DATA_W(DATA_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .load     (frame_done),
        .load_data(frame_data),
        .load_flag(frame_perr),
        .ready    (data_ready),
        .valid    (data_valid),
        .data     (data_out),
        .flag     (parity_err),
        .accepted (accepted)
    );

    assign overrun = overrun_q;

endmodule

// File: doc/sipo_frame_receiver.md
# sipo_frame_receiver

Serial-in, parallel-out frame receiver. It is the receiving end of the single-wire serial bit stream produced by the team's shift-register datapaths. It detects a start bit, shifts in a fixed-width word and an optional even-parity bit, then presents the word on a one-entry valid/ready output buffer. Typical placement: between a serial link pin or a SISO chain output and a parallel consumer such as a FIFO or register file.

## Interface
- `DATA_W`, default 8: data bits per frame; must be ≥ 2.
- `MSB_FIRST`, default 1: 1 = first data bit received is `data_out[DATA_W-1]`; 0 = first data bit is `data_out[0]`.
- `PARITY_EN`, default 1: 1 = one even-parity bit follows the data; 0 = no parity bit.

Ports (name, direction, width, meaning):
- `clk`, in, 1: the single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `serial_in`, in, 1: serial line; idles low; sampled on every rising edge.
- `data_out`, out, DATA_W: received word; stable while `data_valid`=1.
- `data_valid`, out, 1: output buffer holds a word.
- `data_ready`, in, 1: consumer accepts; a transfer occurs on a cycle with `data_valid` & `data_ready`.
- `parity_err`, out, 1: parity flag for the word in `data_out`; qualified by `data_valid`; always 0 when PARITY_EN=0.
- `overrun`, out, 1: one-cycle pulse when a completed frame is dropped.
- `busy`, out, 1: high while a frame is in progress (state ≠ IDLE).

## Operation
- Frame format: start bit (1), then DATA_W data bits, then a parity bit if PARITY_EN=1. Frames have no stop bit, so a new start bit may follow the last bit immediately.
- FSM states:
  - IDLE: if `serial_in`=1, go to SHIFT and clear the bit counter; otherwise stay.
  - SHIFT: each cycle, shift `serial_in` into the shift register and increment the counter. After the DATA_W-th bit, go to PARITY if PARITY_EN=1, else to IDLE and complete the frame.
  - PARITY: sample the parity bit, go to IDLE and complete the frame.
- Parity check: the error is the XOR of the DATA_W data bits and the parity bit; result 1 = error (even parity).
- Frame completion loads the buffer if `data_valid`=0, or if `data_valid`=1 and `data_ready`=1 in the same cycle. The load sets `data_out`, sets `parity_err`, and sets `data_valid`=1.
- Otherwise the frame is dropped: the buffer is unchanged and `overrun` pulses high for 1 cycle.
- A transfer with no simultaneous completion clears `data_valid` on the next edge.
- Counter width is $clog2(DATA_W+1). The counter must not wrap inside a frame.
- The shift register is DATA_W wide. MSB_FIRST=1 shifts left, inserting at bit 0; MSB_FIRST=0 shifts right, inserting at bit DATA_W-1.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `parity_err`=0, `overrun`=0, `busy`=0. The FSM returns to IDLE, and the counter and shift register are zeroed.
- Reset mid-frame or while holding a word: the partial frame or held word is discarded with no `overrun` pulse. Reception resumes from IDLE on the first edge with `reset`=0.
- Cycle T is the edge at which the start bit is sampled.
- Data bits are sampled at edges T+1 … T+DATA_W. The parity bit is sampled at T+DATA_W+1.
- `data_valid` rises after the last sampled edge: after T+DATA_W+1 with parity, or T+DATA_W without. Latency from the last bit to valid is 1 cycle.
- `busy` is high from the edge after T until FSM return.
- Back-to-back frames: with `data_ready` held high, frames arrive every DATA_W+1+PARITY_EN cycles with no loss.
- Overrun decision: sampled on the completion edge; `overrun` is high for exactly the following cycle.
- `serial_in` high while in IDLE always means a start bit. There is no glitch filtering.

## Structure
- Package `sipo_rx_pkg`:
  - enum `rx_state_t` with values IDLE, SHIFT, PARITY.
  - constant START_LEVEL = 1'b1.
  - constant IDLE_LEVEL = 1'b0.
- Sub-module `rx_word_buffer`: the one-entry valid/ready holding register, parameterised on width. It takes a load strobe plus data and flag, and exposes an accepted/dropped indication. The FSM, counter, shift register and parity XOR stay in the top module.

## Test plan
All scenarios use DATA_W=8 and PARITY_EN=1 unless stated.
1. Basic frame, `data_ready`=1: send start, bits 1,0,1,0,0,1,0,1, then parity 0. Require `data_out`=0xA5, `parity_err`=0, and `data_valid` high 1 cycle after the parity edge.
2. Parity error: same data with parity 1. Require `data_out`=0xA5 and `parity_err`=1.
3. Backpressure: hold `data_ready`=0 and send 0x3C, then 0xC3. Require `data_out` to stay 0x3C, an `overrun` 1-cycle pulse on the second frame, and `data_valid` to clear one cycle after `data_ready`=1.
4. Simultaneous accept and complete: assert `data_ready` on the completion edge of frame 2. Require no `overrun` and `data_out` to become frame 2.
5. Reset mid-frame: assert reset after 4 data bits. Require all outputs at 0 and `busy`=0. A following 0x81 frame must be received intact.
6. MSB_FIRST=0, PARITY_EN=0: send bits 1,0,0,0,0,0,0,0. Require `data_out`=0x01, valid at T+9, and `parity_err`=0.
